// File: rtl/tone_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_meter_pkg
//  Description : Shared types and codes for the tone meter and the
//                divider-based tone generators that reuse its sync stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_meter_pkg;

    // Measurement FSM states; one bit is enough for two states.
    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Pitch-trend codes reported alongside each recovered divider.
    localparam logic [1:0] TREND_STEADY = 2'b00;
    localparam logic [1:0] TREND_UP     = 2'b01;  // shorter period, higher pitch
    localparam logic [1:0] TREND_DOWN   = 2'b10;  // longer period, lower pitch

    // Compare a new divider against the previously published one.
    function automatic logic [1:0] trend_code(input logic lt, input logic gt);
        logic [1:0] code;
        code = TREND_STEADY;
        if (lt) begin
            code = TREND_UP;
        end else if (gt) begin
            code = TREND_DOWN;
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer for an asynchronous level plus a
//                one-cycle pulse on either transition of the synced level.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Chain of synchronizer flops, first stage samples the raw input.
    generate
        for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_stage
            if (g == 0) begin : g_first
                // First stage captures the asynchronous input.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_sync[0] <= 1'b0;
                    end else begin
                        r_sync[0] <= din;
                    end
                end
            end else begin : g_next
                // Later stages resolve any metastability of the stage before.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_sync[g] <= 1'b0;
                    end else begin
                        r_sync[g] <= r_sync[g-1];
                    end
                end
            end
        end
    endgenerate

    // Remember last cycle's synced level for transition detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level    = r_sync[SYNC_STAGES-1];
    assign edge_det = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/tone_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tone_meter
//  Description : Measures the half-period of an asynchronous square wave and
//                reports the recovered generator divider, a pitch trend, a
//                silence flag and a strobe for rejected short half-periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 16,
    parameter int TIMEOUT     = 65535   // must fit in CNT_W bits
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tone_in,
    output logic [CNT_W-1:0] divider,
    output logic             valid,
    output logic [1:0]       trend,
    output logic             silent,
    output logic             glitch
);

    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   c_LEN_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   c_MIN_HALF = (CNT_W+1)'(MIN_HALF);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first_pub;   // next publish is the first since entering MEASURE

    logic             w_edge;
    logic             w_level_unused;
    logic             w_at_limit;
    logic             w_long_enough;
    logic [CNT_W:0]   w_half_len;
    logic [1:0]       w_trend;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (tone_in),
        .level    (w_level_unused),
        .edge_det (w_edge)
    );

    // Half-period length is counter+1; widened so it cannot wrap at full scale.
    assign w_half_len    = {1'b0, r_cnt} + c_LEN_ONE;
    assign w_long_enough = (w_half_len >= c_MIN_HALF);
    assign w_at_limit    = (r_cnt == c_TIMEOUT);

    // Trend of the candidate divider (current count) against the last published one.
    always_comb begin
        w_trend = trend_code(r_cnt < divider, r_cnt > divider);
    end

    // Clocks since the last edge: cleared on an edge, saturating at the timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Acquire/measure FSM with registered result, trend and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACQUIRE;
            r_first_pub <= 1'b1;
            divider     <= '0;
            valid       <= 1'b0;
            trend       <= TREND_STEADY;
            silent      <= 1'b1;
            glitch      <= 1'b0;
        end else begin
            valid  <= 1'b0;
            glitch <= 1'b0;
            case (r_state)
                ST_ACQUIRE: begin
                    // First edge only marks the start of a half-period.
                    if (w_edge) begin
                        r_state     <= ST_MEASURE;
                        r_first_pub <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_at_limit) begin
                        // Timeout has priority; a coincident edge restarts acquisition.
                        silent <= 1'b1;
                        if (w_edge) begin
                            r_state     <= ST_MEASURE;
                            r_first_pub <= 1'b1;
                        end else begin
                            r_state <= ST_ACQUIRE;
                        end
                    end else if (w_edge) begin
                        if (w_long_enough) begin
                            divider     <= r_cnt;
                            trend       <= r_first_pub ? TREND_STEADY : w_trend;
                            r_first_pub <= 1'b0;
                            valid       <= 1'b1;
                            silent      <= 1'b0;
                        end else begin
                            // Too short: flag it and resynchronise on a fresh edge.
                            glitch  <= 1'b1;
                            r_state <= ST_ACQUIRE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ACQUIRE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
